// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the dual-port shared-RAM Wishbone subsystem.
//   - WB_ADDR_W / WB_DATA_W : default word-address and data widths, used by
//     both the initiator and the responder side.
//   - wb_init_state_t       : initiator FSM state encoding.
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int unsigned WB_ADDR_W = 10;
   localparam int unsigned WB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_RESP     = 2'd3
   } wb_init_state_t;

endpackage : wb_pkg

// File: rtl/wb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wb_timeout_ctr
// Clear/enable cycle counter with a terminal-count compare. The count stops at
// TIMEOUT_CYCLES and expired_o stays high until the next clear.
// TIMEOUT_CYCLES = 0 removes the counter and ties expired_o low.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : synchronous clear (wins over en_i)
//   en_i        : count enable
//   expired_o   : count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module wb_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired_o = 1'b0;
   end else begin : g_on
      localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (clr_i) begin
            cnt_d = '0;
         end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign expired_o = (cnt_q == LIMIT);
   end

endmodule : wb_timeout_ctr

// File: rtl/wb_port_initiator.sv
// -----------------------------------------------------------------------------
// wb_port_initiator
// Wishbone pipelined-mode initiator for one port of the dual-port shared RAM.
// Takes one command at a time from a valid/ready interface, holds stb and the
// request lines while the responder stalls (collision arbitration), returns
// read data or a timeout error on a one-cycle response pulse.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : command handshake
//   req_we/addr/wdata/sel          : command fields
//   rsp_valid/rsp_rdata/rsp_err    : one-cycle response (no back-pressure)
//   wb_*_o / wb_*_i                : Wishbone master signals
//   stall_count                    : saturating count of stalled stb cycles
// All outputs are registered.
// -----------------------------------------------------------------------------
module wb_port_initiator
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_W         = WB_ADDR_W,
   parameter int unsigned DATA_W         = WB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 15,
   localparam int unsigned SEL_W         = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // command
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [SEL_W-1:0]  req_sel,
   // response
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   // wishbone master
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   input  logic              wb_stall_i,
   input  logic              wb_ack_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   // statistics
   output logic [15:0]       stall_count
);

   wb_init_state_t    state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   logic tmo_clr, tmo_expired;
   logic ack_take, tmo_abort;

   wb_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmo_clr),
      .en_i      ((state_q == ST_REQ) || (state_q == ST_WAIT_ACK)),
      .expired_o (tmo_expired)
   );

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      stall_cnt_d = stall_cnt_q;
      tmo_clr     = 1'b0;
      ack_take    = 1'b0;
      tmo_abort   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               adr_d       = req_addr;
               dat_d       = req_wdata;
               sel_d       = req_sel;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               req_ready_d = 1'b0;
               tmo_clr     = 1'b1;
               state_d     = ST_REQ;
            end
         end

         ST_REQ: begin
            if (wb_stall_i) begin
               // An ack during a stall belongs to no accepted request: ignored.
               if (stall_cnt_q != 16'hFFFF) begin
                  stall_cnt_d = stall_cnt_q + 16'd1;
               end
               tmo_abort = tmo_expired;
            end else if (wb_ack_i) begin
               ack_take = 1'b1;
            end else if (tmo_expired) begin
               tmo_abort = 1'b1;
            end else begin
               stb_d   = 1'b0;
               state_d = ST_WAIT_ACK;
            end
         end

         ST_WAIT_ACK: begin
            // Ack wins over a timeout expiring in the same cycle.
            if (wb_ack_i) begin
               ack_take = 1'b1;
            end else if (tmo_expired) begin
               tmo_abort = 1'b1;
            end
         end

         ST_RESP: begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      if (ack_take || tmo_abort) begin
         cyc_d       = 1'b0;
         stb_d       = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_err_d   = tmo_abort;
         rsp_rdata_d = (ack_take && !we_q) ? wb_dat_i : '0;
         state_d     = ST_RESP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_sel_o    = sel_q;
   assign stall_count = stall_cnt_q;

endmodule : wb_port_initiator

// File: tb/tb_wb_port_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_port_initiator
// Directed self-checking bench for wb_port_initiator (default parameters,
// TIMEOUT_CYCLES = 15). Inputs are driven and outputs sampled 1 ns after the
// rising edge, so each tick() lands inside the next clock cycle.
// -----------------------------------------------------------------------------
module tb_wb_port_initiator;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [SEL_W-1:0]  req_sel;
   logic              rsp_valid, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   logic              wb_cyc_o, wb_stb_o, wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [SEL_W-1:0]  wb_sel_o;
   logic              wb_stall_i, wb_ack_i;
   logic [DATA_W-1:0] wb_dat_i;
   logic [15:0]       stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_port_initiator #(
      .TIMEOUT_CYCLES(15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_sel     (req_sel),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_sel_o    (wb_sel_o),
      .wb_stall_i  (wb_stall_i),
      .wb_ack_i    (wb_ack_i),
      .wb_dat_i    (wb_dat_i),
      .stall_count (stall_count)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command in the current (IDLE) cycle and returns in cycle 1,
   // the first cycle with cyc/stb asserted.
   task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [SEL_W-1:0] sel);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_sel   = sel;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_sel    = '0;
      wb_stall_i = 1'b0;
      wb_ack_i   = 1'b0;
      wb_dat_i   = '0;

      // ---------------- reset state ----------------
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_cyc", 32'(wb_cyc_o), 32'd0);
      check("rst_stb", 32'(wb_stb_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_stall_count", 32'(stall_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- zero-wait read ----------------
      issue(1'b0, 10'h005, 32'h0, 4'hF);
      check("zw_cyc_c1", 32'(wb_cyc_o), 32'd1);
      check("zw_stb_c1", 32'(wb_stb_o), 32'd1);
      check("zw_ready_c1", 32'(req_ready), 32'd0);
      check("zw_adr_c1", 32'(wb_adr_o), 32'h005);
      check("zw_we_c1", 32'(wb_we_o), 32'd0);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hDEADBEEF;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      check("zw_rsp_valid_c2", 32'(rsp_valid), 32'd1);
      check("zw_rdata", rsp_rdata, 32'hDEADBEEF);
      check("zw_err", 32'(rsp_err), 32'd0);
      check("zw_cyc_c2", 32'(wb_cyc_o), 32'd0);
      check("zw_stall_count", 32'(stall_count), 32'd0);
      tick();
      check("zw_ready_c3", 32'(req_ready), 32'd1);
      check("zw_rsp_valid_c3", 32'(rsp_valid), 32'd0);
      check("zw_rdata_c3", rsp_rdata, 32'd0);

      // ---------------- collision stall write ----------------
      wb_stall_i = 1'b1;
      issue(1'b1, 10'h200, 32'h12345678, 4'hF);
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) wb_stall_i = 1'b0;
         check($sformatf("st_stb_c%0d", c), 32'(wb_stb_o), 32'd1);
         check($sformatf("st_adr_c%0d", c), 32'(wb_adr_o), 32'h200);
         check($sformatf("st_dat_c%0d", c), wb_dat_o, 32'h12345678);
         check($sformatf("st_sel_c%0d", c), 32'(wb_sel_o), 32'hF);
         check($sformatf("st_we_c%0d", c), 32'(wb_we_o), 32'd1);
         check($sformatf("st_cnt_c%0d", c), 32'(stall_count), 32'(c - 1));
         tick();
      end
      // cycle 5: accepted, waiting for ack
      check("st_stb_c5", 32'(wb_stb_o), 32'd0);
      check("st_cyc_c5", 32'(wb_cyc_o), 32'd1);
      check("st_rsp_valid_c5", 32'(rsp_valid), 32'd0);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hFFFFFFFF;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      check("st_rsp_valid_c6", 32'(rsp_valid), 32'd1);
      check("st_rdata_write", rsp_rdata, 32'd0);
      check("st_err", 32'(rsp_err), 32'd0);
      check("st_stall_count", 32'(stall_count), 32'd3);
      tick();

      // ---------------- ack during a stall is ignored ----------------
      issue(1'b1, 10'h3C0, 32'hA5A5A5A5, 4'h3);
      wb_stall_i = 1'b1;
      wb_ack_i   = 1'b1;
      tick();
      wb_stall_i = 1'b0;
      wb_ack_i   = 1'b0;
      check("sa_rsp_valid_c2", 32'(rsp_valid), 32'd0);
      check("sa_stb_c2", 32'(wb_stb_o), 32'd1);
      tick();
      check("sa_stb_c3", 32'(wb_stb_o), 32'd0);
      check("sa_rsp_valid_c3", 32'(rsp_valid), 32'd0);
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      check("sa_rsp_valid_c4", 32'(rsp_valid), 32'd1);
      check("sa_stall_count", 32'(stall_count), 32'd4);
      tick();

      // ---------------- delayed ack read ----------------
      issue(1'b0, 10'h0AA, 32'h0, 4'hF);
      check("da_stb_c1", 32'(wb_stb_o), 32'd1);
      tick();
      for (int c = 2; c <= 6; c++) begin
         check($sformatf("da_stb_c%0d", c), 32'(wb_stb_o), 32'd0);
         check($sformatf("da_cyc_c%0d", c), 32'(wb_cyc_o), 32'd1);
         check($sformatf("da_rsp_c%0d", c), 32'(rsp_valid), 32'd0);
         if (c == 6) begin
            wb_ack_i = 1'b1;
            wb_dat_i = 32'hCAFEF00D;
         end
         tick();
      end
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      check("da_rsp_valid", 32'(rsp_valid), 32'd1);
      check("da_rdata", rsp_rdata, 32'hCAFEF00D);
      check("da_err", 32'(rsp_err), 32'd0);
      tick();

      // ---------------- timeout ----------------
      issue(1'b0, 10'h1FF, 32'h0, 4'hF);
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("to_cyc_c%0d", c), 32'(wb_cyc_o), 32'd1);
         check($sformatf("to_rsp_c%0d", c), 32'(rsp_valid), 32'd0);
         tick();
      end
      check("to_cyc_c17", 32'(wb_cyc_o), 32'd0);
      check("to_stb_c17", 32'(wb_stb_o), 32'd0);
      check("to_rsp_valid", 32'(rsp_valid), 32'd1);
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_rdata", rsp_rdata, 32'd0);
      tick();
      check("to_ready_after", 32'(req_ready), 32'd1);
      check("to_err_cleared", 32'(rsp_err), 32'd0);
      // follow-up request completes normally
      issue(1'b0, 10'h011, 32'h0, 4'hF);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h13579BDF;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      check("to2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("to2_rdata", rsp_rdata, 32'h13579BDF);
      check("to2_err", 32'(rsp_err), 32'd0);
      tick();

      // ---------------- ack on the expiry cycle ----------------
      issue(1'b0, 10'h0F0, 32'h0, 4'hF);
      for (int c = 1; c < 16; c++) tick();
      check("tie_cyc_c16", 32'(wb_cyc_o), 32'd1);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h0BADCAFE;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      check("tie_rsp_valid", 32'(rsp_valid), 32'd1);
      check("tie_err", 32'(rsp_err), 32'd0);
      check("tie_rdata", rsp_rdata, 32'h0BADCAFE);
      tick();

      // ---------------- stray ack in IDLE ----------------
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h77777777;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      check("stray_cyc", 32'(wb_cyc_o), 32'd0);
      check("stray_ready", 32'(req_ready), 32'd1);
      tick();
      check("stray_rsp_valid_2", 32'(rsp_valid), 32'd0);

      // ---------------- reset mid-transaction ----------------
      issue(1'b0, 10'h100, 32'h0, 4'hF);
      tick();
      check("rm_cyc_wait", 32'(wb_cyc_o), 32'd1);
      check("rm_stall_count_pre", 32'(stall_count), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check("rm_cyc_async", 32'(wb_cyc_o), 32'd0);
      check("rm_stb_async", 32'(wb_stb_o), 32'd0);
      check("rm_stall_count", 32'(stall_count), 32'd0);
      check("rm_ready_in_reset", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h55555555;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("rm_no_rsp_%0d", c), 32'(rsp_valid), 32'd0);
         check($sformatf("rm_ready_%0d", c), 32'(req_ready), 32'd1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_wb_port_initiator

// File: doc/wb_port_initiator.md
# wb_port_initiator

Wishbone pipelined-mode initiator that drives one port (A or B) of the dual-port shared-RAM subsystem from a simple valid/ready command interface. It issues one transaction at a time and holds `stb` and the address, data and strobe lines while the responder stalls. Stalls occur when the responder's collision arbitration gives the RAM to the other port. It returns read data or an error on a one-cycle response strobe, and aborts on a bounded timeout. Test harnesses and the lab's CPU-side bridge instantiate one per port.

## Interface
- `ADDR_W`, 10: word address width; MSB is the RAM select bit seen by the responder.
- `DATA_W`, 32: data width; `SEL_W = DATA_W/8`.
- `TIMEOUT_CYCLES`, 15: cycles from `stb` assertion without `ack` before abort. Range 1..255; 0 disables the timeout.

Ports:
- Clock and reset (one clock; reset is asynchronous and active-low):
  - `clk` in 1: sole clock, rising edge.
  - `rst_n` in 1: asynchronous, active-low reset.
- Command interface:
  - `req_valid` in 1: command present.
  - `req_ready` out 1: command accepted when `req_valid & req_ready`.
  - `req_we` in 1: 1 = write.
  - `req_addr` in ADDR_W.
  - `req_wdata` in DATA_W.
  - `req_sel` in SEL_W.
- Response interface:
  - `rsp_valid` out 1: one-cycle pulse; no back-pressure.
  - `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
  - `rsp_err` out 1: transaction timed out.
- Wishbone master signals:
  - `wb_cyc_o` out 1.
  - `wb_stb_o` out 1.
  - `wb_we_o` out 1.
  - `wb_adr_o` out ADDR_W.
  - `wb_dat_o` out DATA_W.
  - `wb_sel_o` out SEL_W.
  - `wb_stall_i` in 1.
  - `wb_ack_i` in 1.
  - `wb_dat_i` in DATA_W.
- Statistics:
  - `stall_count` out 16: saturating count of cycles with `wb_stb_o & wb_stall_i`.

## Operation
- The FSM has four states: IDLE, REQ, WAIT_ACK and RESP. All outputs are registered.
- **IDLE:** `req_ready`=1. On handshake:
  - latch we/addr/wdata/sel into the Wishbone output registers;
  - set `cyc` and `stb`;
  - go to REQ.
- **REQ:** `cyc`=`stb`=1. Hold all Wishbone outputs stable.
  - If `wb_stall_i`=0, the request is accepted: clear `stb` next cycle.
  - Same cycle `ack`=1 → RESP. Otherwise → WAIT_ACK.
  - If `wb_stall_i`=1, stay in REQ and increment `stall_count`, saturating at 0xFFFF.
- **WAIT_ACK:** `cyc`=1, `stb`=0. On `wb_ack_i` → RESP and capture `wb_dat_i` if it was a read.
- **RESP:** `cyc`=0, `rsp_valid`=1 for exactly one cycle → IDLE. `req_ready` is 0 in RESP.
- `wb_ack_i` seen while in REQ with `wb_stall_i`=1 is ignored. It belongs to no accepted request.
- `wb_ack_i` seen in IDLE or RESP is ignored.
- **Timeout:**
  - The counter clears on the IDLE→REQ transition and increments every cycle in REQ or WAIT_ACK.
  - When it reaches `TIMEOUT_CYCLES` with no `ack` that cycle: drop `cyc`/`stb` next cycle, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - If `ack` and the timeout coincide, `ack` wins and `rsp_err`=0.
- `rsp_rdata` is 0 for writes.

## Timing
- Reset values: `req_ready`=1 and `rst_n`-async. Every other output is 0, including `stall_count`; the FSM is in IDLE.
- A reset asserted mid-transaction drops `cyc`/`stb` asynchronously and discards the transaction; no `rsp_valid` is produced.
- Best case: handshake at cycle 0, then `cyc`/`stb` at cycle 1. With `stall`=0 and `ack`=1 at cycle 1, `rsp_valid` is at cycle 2 and `req_ready` is 1 again at cycle 3.
- Throughput is one transaction per 3 cycles minimum.
- Each stalled cycle adds one cycle of latency. Each cycle of `ack` delay after acceptance adds one cycle.
- `cyc` is never deasserted while `stb`=1 except on timeout or reset.

## Structure
- Shared package `wb_pkg` holds:
  - `wb_init_state_t` enum (IDLE, REQ, WAIT_ACK, RESP);
  - the default `ADDR_W`/`DATA_W` localparams, shared with the responder side.
- One natural sub-module, `wb_timeout_ctr`: a clear/enable counter with `TIMEOUT_CYCLES` compare and a `expired` flag. Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It is tied off when the parameter is 0.

## Test plan
- **Zero-wait read:** req read addr 0x005; responder `stall`=0, `ack` at cycle 1 with `dat_i`=0xDEADBEEF. Expect `rsp_valid` at cycle 2, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `stall_count`=0.
- **Collision stall:** write addr 0x200, data 0x12345678, sel 0xF; hold `stall`=1 for 3 cycles, then `ack` one cycle later.
  - Expect `adr`/`dat`/`sel`/`we` constant across the stall and `stb` high for 4 cycles.
  - Expect `stall_count`=3, `rsp_rdata`=0, `rsp_valid` 2 cycles after acceptance.
- **Delayed ack:** read accepted with `stall`=0, `ack` 5 cycles later. Expect `stb` low in WAIT_ACK, `cyc` high throughout, and correct data returned.
- **Timeout:** with `TIMEOUT_CYCLES`=15, no `ack` is ever given.
  - Expect `cyc` to drop 16 cycles after `stb` rises.
  - Expect `rsp_err`=1 and `rsp_rdata`=0.
  - A second request then completes normally.
- **Ack-timeout tie and stray ack:** `ack` on exactly the expiry cycle gives `rsp_err`=0. An `ack` pulse in IDLE produces no `rsp_valid`.
- **Reset mid-operation:** deassert `rst_n` in WAIT_ACK. Expect `cyc`/`stb`=0 immediately, no response, `stall_count`=0, and `req_ready`=1 after release.
